risc_v_mike_lsu: RTL and testbench
==================================

Name: risc_v_mike_lsu

Overview:
Load/store unit between the core's MEM stage and data memory / MMIO. Takes a byte address, a funct3 and a direction, then maps the address onto the text/data/stack/MMIO memory map. It issues one or two word-wide requests, splitting accesses that cross a word boundary, and returns sign- or zero-extended load data. One operation is in flight at a time, with a valid/ready handshake upstream and a req/ack handshake downstream.

Parameters:
DATA_MEM_DEPTH, 1024, data memory size in bytes; lower half backs .data, upper half backs .stack
MMIO_MEM_SIZE, 64, MMIO window size in bytes starting at 0xFFFF0000
DMEM_AW, $clog2(DATA_MEM_DEPTH/4), word-index width of dmem_addr

Ports:
clk  in  1  core clock; the block uses this single clock
rst  in  1  reset, synchronous, active-high
lsu_valid  in  1  operation request
lsu_ready  out  1  high only in IDLE
lsu_we  in  1  1 = store, 0 = load
lsu_funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW encodings)
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data, right-aligned
lsu_done  out  1  one-cycle completion pulse
lsu_fault  out  1  valid with lsu_done; access fault
lsu_rdata  out  32  extended load data; held until next accept
dmem_req  out  1  memory request; held until dmem_ack
dmem_we  out  1  write enable
dmem_mmio  out  1  1 = target is MMIO window, 0 = data memory
dmem_addr  out  DMEM_AW  word index
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-aligned write data
dmem_ack  in  1  request accepted; dmem_rdata valid same cycle for reads
dmem_rdata  in  32  read word

Behaviour:
- Reset: the block uses a single clock, clk; rst is synchronous and active-high. On reset, state=IDLE, lsu_ready=1, and lsu_done, lsu_fault, dmem_req and dmem_we are all 0. lsu_rdata, dmem_addr, dmem_be and dmem_wdata reset to 0.
- A rst that arrives mid-operation abandons the access: the next cycle dmem_req=0 and no lsu_done is produced.
- Accept: an operation is accepted when lsu_valid && lsu_ready. All inputs are registered on acceptance, so upstream may change them afterwards.
- Region decode, applied to the first and last byte of the access:
  - DATA: 0x10010000 to +DATA_MEM_DEPTH/2-1, at phys byte offset addr-0x10010000.
  - STACK: base = 0x7FFFF000 - DATA_MEM_DEPTH/2, up to 0x7FFFEFFF, at phys byte offset DATA_MEM_DEPTH/2 + (addr-base).
  - MMIO: 0xFFFF0000 to +MMIO_MEM_SIZE-1, at offset addr-0xFFFF0000, with dmem_mmio=1.
  - Anything else, including .text, is a fault.
- Fault conditions:
  - First and last byte fall in different regions, or either byte is outside every region.
  - Illegal funct3: a load with 011/110/111, or a store with funct3 above 010.
  - A faulting operation issues no dmem_req; the state goes IDLE -> DONE.
- Size: 1/2/4 bytes. With off = phys[1:0], mask = (0001/0011/1111) << off across 8 bits. be0 = mask[3:0] and be1 = mask[7:4]. A second beat is needed iff be1 != 0.
- Store data: dmem_wdata = lsu_wdata rotated left by 8*off, and is the same on both beats. Load beats use be = 1111 (full-word read).
- Beat addressing: beat0 uses word index phys>>2 and beat1 uses index+1.
- FSM transitions:
  - IDLE -> BEAT0 on a legal accept; IDLE -> DONE on a faulting accept.
  - BEAT0 holds dmem_req and all fields until ack. On ack it goes to BEAT1 if split, else to DONE.
  - BEAT1 holds until ack, then goes to DONE.
  - DONE pulses lsu_done=1 for one cycle, then returns to IDLE.
- Load assembly: the beat0 word is captured on ack. The combined 64-bit value is {beat1, beat0} >> 8*off, truncated to size. LB and LH sign-extend; LBU, LHU and LW zero-extend. lsu_rdata is written on the cycle that enters DONE.
- Latency: accept at cycle T, dmem_req at T+1. A zero-wait ack gives lsu_done at T+2 for a single beat and T+3 for a split. A fault gives lsu_done at T+1.
- lsu_fault is 0 whenever lsu_done=0. On a fault, lsu_rdata is 0.

Test Plan:
- SW 0xDEADBEEF to 0x10010008 with ack the same cycle -> dmem_addr=2, be=1111, wdata=0xDEADBEEF, dmem_mmio=0, single beat, lsu_done at T+2, fault=0.
- LB at 0x10010001 with rdata 0x12348056 -> lsu_rdata=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LW at 0x10010006 with word1=0xAABBCCDD and word2=0x11223344 -> two beats at addr 1 then 2, be=1111, lsu_rdata=0x3344AABB. Hold ack low 3 cycles on beat0 -> request fields stay stable.
- SH 0x0000CAFE to 0x7FFFEFFE -> dmem_addr=255, be=1100, wdata=0xCAFE0000. SB 0x5A to 0xFFFF0004 -> dmem_mmio=1, addr=1, be=0001.
- LW at 0x00400000, LW at 0x100101FE (crosses region end), and a load with funct3=111 -> each gives lsu_fault=1, no dmem_req, lsu_done at T+1.
- Assert rst while in BEAT0 waiting for ack -> next cycle dmem_req=0, lsu_ready=1, no lsu_done. A new LW then completes normally.

Source files
------------

// File: rtl/risc_v_mike_lsu_if.sv
// Word-wide request/acknowledge bus between the load/store unit and
// data memory / MMIO. The LSU is the master; the memory side is the slave.
interface risc_v_mike_lsu_if #(
  parameter int DMEM_AW = 8
);
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_mmio;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [3:0]         dmem_be;
  logic [31:0]        dmem_wdata;
  logic               dmem_ack;
  logic [31:0]        dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_mmio, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_mmio, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/risc_v_mike_lsu.sv
// Load/store unit: decodes a byte address onto the data/stack/MMIO map,
// issues one or two word requests (splitting word-crossing accesses) and
// returns sign- or zero-extended load data. One operation in flight.
module risc_v_mike_lsu #(
  parameter int DATA_MEM_DEPTH = 1024,
  parameter int MMIO_MEM_SIZE  = 64,
  parameter int DMEM_AW        = $clog2(DATA_MEM_DEPTH / 4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_done,
  output logic              lsu_fault,
  output logic [31:0]       lsu_rdata,
  risc_v_mike_lsu_if.master dmem
);

  // Physical byte-offset width inside the data memory.
  localparam int          PW         = DMEM_AW + 2;
  localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] HALF       = 32'(DATA_MEM_DEPTH / 2);
  localparam logic [31:0] STACK_BASE = 32'h7FFF_F000 - HALF;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_SIZE  = 32'(MMIO_MEM_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_DONE} state_e;
  typedef enum logic [1:0] {RG_NONE, RG_DATA, RG_STACK, RG_MMIO} region_e;

  // Unsigned wrap-around compare: (a - base) < size is true only inside the window.
  function automatic region_e region_of(input logic [31:0] a);
    if ((a - DATA_BASE) < HALF)       return RG_DATA;
    if ((a - STACK_BASE) < HALF)      return RG_STACK;
    if ((a - MMIO_BASE) < MMIO_SIZE)  return RG_MMIO;
    return RG_NONE;
  endfunction

  state_e             state_q, state_d;
  logic               we_q, mmio_q, split_q, fault_q;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic [DMEM_AW-1:0] idx_q;
  logic [3:0]         be0_q, be1_q;
  logic [31:0]        wdata_q, word0_q, rdata_q;

  region_e     first_rg, last_rg;
  logic [1:0]  size_m1;
  logic [3:0]  base_mask;
  logic [7:0]  mask;
  logic [PW-1:0] phys;
  logic        legal_f3, in_fault;
  logic [31:0] wdata_rot;

  logic        accept, busy, in_beat1, load_last;
  logic [31:0] lo_word, hi_word, aligned, load_ext;

  assign accept   = lsu_valid && lsu_ready;
  assign busy     = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign in_beat1 = (state_q == ST_BEAT1);

  // Decode the incoming request: size, legality, region, lane mask and store rotation.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    size_m1   = 2'd3;
    base_mask = 4'b1111;
    phys      = lsu_addr[PW-1:0] - DATA_BASE[PW-1:0];
    wdata_rot = lsu_wdata;
    case (lsu_funct3[1:0])
      2'b00:   begin size_m1 = 2'd0; base_mask = 4'b0001; end
      2'b01:   begin size_m1 = 2'd1; base_mask = 4'b0011; end
      default: begin size_m1 = 2'd3; base_mask = 4'b1111; end
    endcase
    first_rg = region_of(lsu_addr);
    last_rg  = region_of(lsu_addr + {30'b0, size_m1});
    legal_f3 = lsu_we ? (lsu_funct3 <= 3'b010)
                      : (lsu_funct3 != 3'b011 && lsu_funct3 != 3'b110 &&
                         lsu_funct3 != 3'b111);
    in_fault = !legal_f3 || (first_rg == RG_NONE) || (first_rg != last_rg);
    case (first_rg)
      RG_STACK: phys = lsu_addr[PW-1:0] - STACK_BASE[PW-1:0] + HALF[PW-1:0];
      RG_MMIO:  phys = lsu_addr[PW-1:0] - MMIO_BASE[PW-1:0];
      default:  phys = lsu_addr[PW-1:0] - DATA_BASE[PW-1:0];
    endcase
    mask = {4'b0000, base_mask} << phys[1:0];
    case (phys[1:0])
      2'd1:    wdata_rot = {lsu_wdata[23:0], lsu_wdata[31:24]};
      2'd2:    wdata_rot = {lsu_wdata[15:0], lsu_wdata[31:16]};
      2'd3:    wdata_rot = {lsu_wdata[7:0],  lsu_wdata[31:8]};
      default: wdata_rot = lsu_wdata;
    endcase
  end

  // Assemble the {beat1, beat0} window shifted by the byte offset, then extend.
  always_comb begin
    lo_word = in_beat1 ? word0_q : dmem.dmem_rdata;
    hi_word = dmem.dmem_rdata;
    case (off_q)
      2'd1:    aligned = {hi_word[7:0],  lo_word[31:8]};
      2'd2:    aligned = {hi_word[15:0], lo_word[31:16]};
      2'd3:    aligned = {hi_word[23:0], lo_word[31:24]};
      default: aligned = lo_word;
    endcase
    case (funct3_q)
      3'b000:  load_ext = {{24{aligned[7]}}, aligned[7:0]};
      3'b001:  load_ext = {{16{aligned[15]}}, aligned[15:0]};
      3'b100:  load_ext = {24'b0, aligned[7:0]};
      3'b101:  load_ext = {16'b0, aligned[15:0]};
      default: load_ext = aligned;
    endcase
  end

  assign load_last = busy && dmem.dmem_ack && !we_q && (in_beat1 || !split_q);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = in_fault ? ST_DONE : ST_BEAT0;
      ST_BEAT0: if (dmem.dmem_ack) state_d = split_q ? ST_BEAT1 : ST_DONE;
      ST_BEAT1: if (dmem.dmem_ack) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture the operation on accept, the first read beat, and the final load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      idx_q    <= '0;
      mmio_q   <= 1'b0;
      be0_q    <= '0;
      be1_q    <= '0;
      split_q  <= 1'b0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      word0_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        we_q     <= lsu_we;
        funct3_q <= lsu_funct3;
        off_q    <= phys[1:0];
        idx_q    <= phys[PW-1:2];
        mmio_q   <= (first_rg == RG_MMIO);
        be0_q    <= lsu_we ? mask[3:0] : 4'b1111;
        be1_q    <= lsu_we ? mask[7:4] : 4'b1111;
        split_q  <= |mask[7:4];
        wdata_q  <= wdata_rot;
        fault_q  <= in_fault;
        rdata_q  <= '0;
      end
      if (state_q == ST_BEAT0 && dmem.dmem_ack) word0_q <= dmem.dmem_rdata;
      if (load_last) rdata_q <= load_ext;
    end
  end

  assign lsu_ready  = (state_q == ST_IDLE);
  assign lsu_done   = (state_q == ST_DONE);
  assign lsu_fault  = (state_q == ST_DONE) && fault_q;
  assign lsu_rdata  = rdata_q;

  // Request fields are driven only while a beat is outstanding.
  assign dmem.dmem_req   = busy;
  assign dmem.dmem_we    = busy && we_q;
  assign dmem.dmem_mmio  = busy && mmio_q;
  assign dmem.dmem_addr  = !busy ? '0 : (in_beat1 ? idx_q + DMEM_AW'(1) : idx_q);
  assign dmem.dmem_be    = !busy ? 4'b0000 : (in_beat1 ? be1_q : be0_q);
  assign dmem.dmem_wdata = busy ? wdata_q : 32'b0;

endmodule

// File: tb/tb_risc_v_mike_lsu.sv
// Directed bench for risc_v_mike_lsu: a memory responder with programmable
// wait states, and a scoreboard of expected completions.
module tb_risc_v_mike_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_ready, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_done, lsu_fault;
  logic [31:0] lsu_rdata;

  always #5 clk = ~clk;

  risc_v_mike_lsu_if #(.DMEM_AW(8)) dmem_bus ();

  risc_v_mike_lsu #(
    .DATA_MEM_DEPTH(1024),
    .MMIO_MEM_SIZE (64),
    .DMEM_AW       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_we     (lsu_we),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_done   (lsu_done),
    .lsu_fault  (lsu_fault),
    .lsu_rdata  (lsu_rdata),
    .dmem       (dmem_bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] w0;
    logic [31:0] w1;
    int          wait0;
    int          beats;
    logic [7:0]  idx;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] wd;
    logic        mmio;
    logic        fault;
    logic        check_rd;
    logic [31:0] rd;
  } op_t;

  typedef struct {
    logic        fault;
    logic        check_rd;
    logic [31:0] rdata;
    int          latency;
    int          beats;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, act as memory, then compare against the scoreboard entry.
  task automatic run_op(input string name, input op_t op);
    exp_t e;
    exp_t got;
    int   cyc, beat, stall, reqs;
    logic acked;
    e.fault    = op.fault;
    e.check_rd = op.check_rd;
    e.rdata    = op.rd;
    e.beats    = op.beats;
    e.latency  = op.fault ? 1 : op.beats + op.wait0 + 1;
    sb.push_back(e);

    @(negedge clk);
    lsu_valid  = 1'b1;
    lsu_we     = op.we;
    lsu_funct3 = op.f3;
    lsu_addr   = op.addr;
    lsu_wdata  = op.wdata;
    @(negedge clk);
    // Scramble upstream inputs: the DUT must have registered them.
    lsu_valid  = 1'b0;
    lsu_we     = ~op.we;
    lsu_funct3 = 3'b111;
    lsu_addr   = $urandom;
    lsu_wdata  = $urandom;

    cyc = 1; beat = 0; stall = 0; reqs = 0; acked = 1'b0;
    while (!lsu_done && cyc < 40) begin
      if (dmem_bus.dmem_req) begin
        check({name, " addr"}, 32'(dmem_bus.dmem_addr), 32'(op.idx) + 32'(beat));
        check({name, " be"}, 32'(dmem_bus.dmem_be), 32'((beat == 0) ? op.be0 : op.be1));
        check({name, " we"}, 32'(dmem_bus.dmem_we), 32'(op.we));
        check({name, " mmio"}, 32'(dmem_bus.dmem_mmio), 32'(op.mmio));
        if (op.we) check({name, " wdata"}, dmem_bus.dmem_wdata, op.wd);
        if (beat == 0 && stall < op.wait0) begin
          dmem_bus.dmem_ack = 1'b0;
          stall++;
        end else begin
          dmem_bus.dmem_ack   = 1'b1;
          dmem_bus.dmem_rdata = (beat == 0) ? op.w0 : op.w1;
          acked = 1'b1;
          reqs++;
        end
      end
      @(negedge clk);
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = $urandom;
      if (acked) begin
        beat++;
        acked = 1'b0;
      end
      cyc++;
    end

    got = sb.pop_front();
    check({name, " done_seen"}, 32'(lsu_done), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(got.latency));
    check({name, " beats"}, 32'(reqs), 32'(got.beats));
    check({name, " fault"}, 32'(lsu_fault), 32'(got.fault));
    if (got.check_rd) check({name, " rdata"}, lsu_rdata, got.rdata);
    @(negedge clk);
    check({name, " done_pulse"}, 32'(lsu_done), 32'd0);
    check({name, " ready_after"}, 32'(lsu_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    lsu_valid  = 1'b0;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b000;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(lsu_ready), 32'd1);
    check("rst done", 32'(lsu_done), 32'd0);
    check("rst fault", 32'(lsu_fault), 32'd0);
    check("rst req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst we", 32'(dmem_bus.dmem_we), 32'd0);
    check("rst rdata", lsu_rdata, 32'd0);
    check("rst addr", 32'(dmem_bus.dmem_addr), 32'd0);
    check("rst be", 32'(dmem_bus.dmem_be), 32'd0);
    check("rst wdata", dmem_bus.dmem_wdata, 32'd0);
    rst = 1'b0;

    run_op("sw_data", '{we:1, f3:3'b010, addr:32'h1001_0008, wdata:32'hDEAD_BEEF,
      w0:0, w1:0, wait0:0, beats:1, idx:8'd2, be0:4'b1111, be1:4'b0000,
      wd:32'hDEAD_BEEF, mmio:0, fault:0, check_rd:0, rd:0});
    run_op("lb_neg", '{we:0, f3:3'b000, addr:32'h1001_0001, wdata:0,
      w0:32'h1234_8056, w1:0, wait0:0, beats:1, idx:8'd0, be0:4'b1111, be1:4'b1111,
      wd:0, mmio:0, fault:0, check_rd:1, rd:32'hFFFF_FF80});
    run_op("lbu", '{we:0, f3:3'b100, addr:32'h1001_0001, wdata:0,
      w0:32'h1234_8056, w1:0, wait0:0, beats:1, idx:8'd0, be0:4'b1111, be1:4'b1111,
      wd:0, mmio:0, fault:0, check_rd:1, rd:32'h0000_0080});
    run_op("lw_split", '{we:0, f3:3'b010, addr:32'h1001_0006, wdata:0,
      w0:32'hAABB_CCDD, w1:32'h1122_3344, wait0:3, beats:2, idx:8'd1, be0:4'b1111,
      be1:4'b1111, wd:0, mmio:0, fault:0, check_rd:1, rd:32'h3344_AABB});
    run_op("lh_neg", '{we:0, f3:3'b001, addr:32'h1001_0002, wdata:0,
      w0:32'h8001_0000, w1:0, wait0:0, beats:1, idx:8'd0, be0:4'b1111, be1:4'b1111,
      wd:0, mmio:0, fault:0, check_rd:1, rd:32'hFFFF_8001});
    run_op("sh_stack", '{we:1, f3:3'b001, addr:32'h7FFF_EFFE, wdata:32'h0000_CAFE,
      w0:0, w1:0, wait0:0, beats:1, idx:8'd255, be0:4'b1100, be1:4'b0000,
      wd:32'hCAFE_0000, mmio:0, fault:0, check_rd:0, rd:0});
    run_op("sh_split", '{we:1, f3:3'b001, addr:32'h1001_0003, wdata:32'h0000_1234,
      w0:0, w1:0, wait0:1, beats:2, idx:8'd0, be0:4'b1000, be1:4'b0001,
      wd:32'h3400_0012, mmio:0, fault:0, check_rd:0, rd:0});
    run_op("sb_mmio", '{we:1, f3:3'b000, addr:32'hFFFF_0004, wdata:32'h0000_005A,
      w0:0, w1:0, wait0:0, beats:1, idx:8'd1, be0:4'b0001, be1:4'b0000,
      wd:32'h0000_005A, mmio:1, fault:0, check_rd:0, rd:0});
    run_op("lw_text", '{we:0, f3:3'b010, addr:32'h0040_0000, wdata:0,
      w0:0, w1:0, wait0:0, beats:0, idx:0, be0:0, be1:0,
      wd:0, mmio:0, fault:1, check_rd:1, rd:0});
    run_op("lw_cross", '{we:0, f3:3'b010, addr:32'h1001_01FE, wdata:0,
      w0:0, w1:0, wait0:0, beats:0, idx:0, be0:0, be1:0,
      wd:0, mmio:0, fault:1, check_rd:1, rd:0});
    run_op("ld_f3_111", '{we:0, f3:3'b111, addr:32'h1001_0000, wdata:0,
      w0:0, w1:0, wait0:0, beats:0, idx:0, be0:0, be1:0,
      wd:0, mmio:0, fault:1, check_rd:1, rd:0});
    run_op("st_f3_011", '{we:1, f3:3'b011, addr:32'h1001_0000, wdata:32'h1,
      w0:0, w1:0, wait0:0, beats:0, idx:0, be0:0, be1:0,
      wd:0, mmio:0, fault:1, check_rd:1, rd:0});

    // Abandon an access that is waiting for its first ack.
    @(negedge clk);
    lsu_valid  = 1'b1;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b010;
    lsu_addr   = 32'h1001_0010;
    @(negedge clk);
    lsu_valid = 1'b0;
    check("abort req_before", 32'(dmem_bus.dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort req", 32'(dmem_bus.dmem_req), 32'd0);
    check("abort ready", 32'(lsu_ready), 32'd1);
    check("abort done", 32'(lsu_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort no_done", 32'(lsu_done), 32'd0);

    run_op("lw_after_rst", '{we:0, f3:3'b010, addr:32'h1001_0010, wdata:0,
      w0:32'hCAFE_BABE, w1:0, wait0:0, beats:1, idx:8'd4, be0:4'b1111, be1:4'b1111,
      wd:0, mmio:0, fault:0, check_rd:1, rd:32'hCAFE_BABE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
